// File: rtl/nrf_cmd_seq_if.sv
// rtl/nrf_cmd_seq_if.sv - host-side command/payload bus of the nRF24L01 transaction sequencer
//
// Signals:
//   req, cmd[7:0], len[5:0]   host command request with command byte and payload count
//   pl_data[7:0], pl_ack      transmit payload byte and its consume strobe
//   busy, ready, done         transaction in flight / init complete / end-of-transaction pulse
//   status[7:0]               first byte received in the most recent transaction
//   rd_data[7:0], rd_valid    received payload byte and its strobe
// Modports: master = host logic, slave = sequencer.

interface nrf_cmd_seq_if;
  logic       req;
  logic [7:0] cmd;
  logic [5:0] len;
  logic [7:0] pl_data;
  logic       pl_ack;
  logic       busy;
  logic       ready;
  logic       done;
  logic [7:0] status;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output req, cmd, len, pl_data,
    input  pl_ack, busy, ready, done, status, rd_data, rd_valid
  );

  modport slave (
    input  req, cmd, len, pl_data,
    output pl_ack, busy, ready, done, status, rd_data, rd_valid
  );
endinterface

// File: rtl/nrf_cmd_seq.sv
// rtl/nrf_cmd_seq.sv - nRF24L01 CSN-framed command sequencer with power-on init table
//
// Ports:
//   clk_10           system clock, 10 MHz
//   rst              asynchronous, active-high reset
//   host             nrf_cmd_seq_if.slave host command/payload bus
//   byte_start       one-cycle launch pulse to the single-byte SPI engine
//   byte_data[7:0]   byte to the engine, held from byte_start until byte_done
//   byte_done        engine byte-complete pulse
//   byte_rx[7:0]     byte shifted in by the engine, valid with byte_done
//   csn              radio chip select, active low
// Every output is registered; the next-state logic computes all of them together.

module nrf_cmd_seq #(
  parameter int PWRUP_CYCLES = 1000000,
  parameter int CSN_GAP      = 4
) (
  input  logic          clk_10,
  input  logic          rst,
  nrf_cmd_seq_if.slave  host,
  output logic          byte_start,
  output logic [7:0]    byte_data,
  input  logic          byte_done,
  input  logic [7:0]    byte_rx,
  output logic          csn
);

  localparam int PW = $clog2(PWRUP_CYCLES + 1);
  localparam int GW = $clog2(CSN_GAP + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(PWRUP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CSN_GAP - 1);

  typedef enum logic [2:0] {
    PWRUP, INIT_CMD, INIT_DATA, IDLE, SEL, CMD, PAYLOAD, GAP
  } state_t;

  // Init table entry: {register write command, data byte}.
  function automatic logic [15:0] init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    init_entry = 16'h200E;
      3'd1:    init_entry = 16'h2100;
      3'd2:    init_entry = 16'h2303;
      3'd3:    init_entry = 16'h2502;
      default: init_entry = 16'h2606;
    endcase
  endfunction

  state_t        state, state_d;
  logic [PW-1:0] pwr_cnt, pwr_cnt_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic [2:0]    init_idx, init_idx_d;
  logic [5:0]    rem, rem_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          waiting, waiting_d;
  logic          csn_d, byte_start_d;
  logic [7:0]    byte_data_d;
  logic          pl_ack_q, pl_ack_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic [15:0]   entry;

  assign entry = init_entry(init_idx);

  always_comb begin
    state_d      = state;
    pwr_cnt_d    = pwr_cnt;
    gap_cnt_d    = gap_cnt;
    init_idx_d   = init_idx;
    rem_d        = rem;
    cmd_d        = cmd_q;
    waiting_d    = waiting;
    csn_d        = csn;
    byte_start_d = 1'b0;
    byte_data_d  = byte_data;
    pl_ack_d     = 1'b0;
    busy_d       = busy_q;
    ready_d      = ready_q;
    done_d       = 1'b0;
    status_d     = status_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;

    case (state)
      PWRUP: begin
        if (pwr_cnt == PWR_LAST) begin
          init_idx_d = 3'd0;
          state_d    = SEL;
        end else begin
          pwr_cnt_d = pwr_cnt + 1'b1;
        end
      end

      IDLE: begin
        if (host.req) begin
          cmd_d   = host.cmd;
          rem_d   = (host.len > 6'd32) ? 6'd32 : host.len;
          busy_d  = 1'b1;
          state_d = SEL;
        end
      end

      // One cycle of CSN low before the first byte; init frames share this step.
      SEL: begin
        csn_d     = 1'b0;
        waiting_d = 1'b0;
        state_d   = ready_q ? CMD : INIT_CMD;
      end

      INIT_CMD: begin
        if (!waiting) begin
          byte_start_d = 1'b1;
          byte_data_d  = entry[15:8];
          waiting_d    = 1'b1;
        end else if (byte_done) begin
          byte_start_d = 1'b1;
          byte_data_d  = entry[7:0];
          state_d      = INIT_DATA;
        end
      end

      INIT_DATA: begin
        if (byte_done) begin
          csn_d     = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end

      CMD: begin
        if (!waiting) begin
          byte_start_d = 1'b1;
          byte_data_d  = cmd_q;
          waiting_d    = 1'b1;
        end else if (byte_done) begin
          status_d = byte_rx;
          if (rem == 6'd0) begin
            csn_d     = 1'b1;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            // Launch the first payload byte straight away to keep the 1-cycle turnaround.
            byte_start_d = 1'b1;
            pl_ack_d     = 1'b1;
            byte_data_d  = host.pl_data;
            state_d      = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (byte_done) begin
          rd_data_d  = byte_rx;
          rd_valid_d = 1'b1;
          rem_d      = rem - 1'b1;
          if (rem == 6'd1) begin
            csn_d     = 1'b1;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            byte_start_d = 1'b1;
            pl_ack_d     = 1'b1;
            byte_data_d  = host.pl_data;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (ready_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (init_idx == 3'd4) begin
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            init_idx_d = init_idx + 1'b1;
            state_d    = SEL;
          end
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end

      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      state      <= PWRUP;
      pwr_cnt    <= '0;
      gap_cnt    <= '0;
      init_idx   <= 3'd0;
      rem        <= 6'd0;
      cmd_q      <= 8'h00;
      waiting    <= 1'b0;
      csn        <= 1'b1;
      byte_start <= 1'b0;
      byte_data  <= 8'h00;
      pl_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_d;
      pwr_cnt    <= pwr_cnt_d;
      gap_cnt    <= gap_cnt_d;
      init_idx   <= init_idx_d;
      rem        <= rem_d;
      cmd_q      <= cmd_d;
      waiting    <= waiting_d;
      csn        <= csn_d;
      byte_start <= byte_start_d;
      byte_data  <= byte_data_d;
      pl_ack_q   <= pl_ack_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      status_q   <= status_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign host.pl_ack   = pl_ack_q;
  assign host.busy     = busy_q;
  assign host.ready    = ready_q;
  assign host.done     = done_q;
  assign host.status   = status_q;
  assign host.rd_data  = rd_data_q;
  assign host.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_nrf_cmd_seq.sv
// tb/tb_nrf_cmd_seq.sv - directed self-checking bench for nrf_cmd_seq

module tb_nrf_cmd_seq;

  localparam int PWR = 20;
  localparam int GAPC = 4;

  logic       clk_10 = 1'b0;
  logic       rst = 1'b1;
  logic       byte_start, byte_done, csn;
  logic [7:0] byte_data, byte_rx;

  nrf_cmd_seq_if ifc();

  nrf_cmd_seq #(.PWRUP_CYCLES(PWR), .CSN_GAP(GAPC)) dut (
    .clk_10     (clk_10),
    .rst        (rst),
    .host       (ifc),
    .byte_start (byte_start),
    .byte_data  (byte_data),
    .byte_done  (byte_done),
    .byte_rx    (byte_rx),
    .csn        (csn)
  );

  always #50 clk_10 = ~clk_10;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] init_exp [10] = '{8'h20, 8'h0E, 8'h21, 8'h00, 8'h23, 8'h03, 8'h25, 8'h02, 8'h26, 8'h06};

  // Bus monitor: frames, transmitted bytes, strobes and done latency.
  int         cyc = 0, dones = 0, pl_acks = 0, bad_starts = 0, frame_bytes = 0;
  int         last_bd = 0, done_lat = 0;
  int         frame_sizes[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  logic       prev_csn = 1'b1;

  initial begin
    forever begin
      @(negedge clk_10);
      cyc++;
      if (byte_start) begin
        if (csn) bad_starts++;
        else begin
          frame_bytes++;
          tx_q.push_back(byte_data);
        end
      end
      if (ifc.pl_ack) pl_acks++;
      if (ifc.rd_valid) rd_q.push_back(ifc.rd_data);
      if (byte_done) last_bd = cyc;
      if (ifc.done) begin
        dones++;
        done_lat = cyc - last_bd;
      end
      if (!prev_csn && csn) begin
        frame_sizes.push_back(frame_bytes);
        frame_bytes = 0;
      end
      prev_csn = csn;
    end
  end

  // Byte engine: byte_done 8 cycles after byte_start, rx = 0xA0 + byte index in frame.
  int eidx = 0;
  initial begin
    byte_done = 1'b0;
    byte_rx   = 8'h00;
    forever begin
      @(negedge clk_10);
      if (csn) eidx = 0;
      if (byte_start) begin
        repeat (8) @(posedge clk_10);
        #1;
        byte_done = 1'b1;
        byte_rx   = 8'hA0 + eidx[7:0];
        eidx++;
        @(posedge clk_10);
        #1;
        byte_done = 1'b0;
      end
    end
  end

  // Host payload source: presents pl_mem[pl_idx], advances after each pl_ack.
  logic [7:0] pl_mem [64];
  int         pl_idx = 0;
  initial begin
    logic a;
    ifc.pl_data = 8'h00;
    forever begin
      @(negedge clk_10);
      a = ifc.pl_ack;
      @(posedge clk_10);
      #1;
      if (a) pl_idx++;
      if (!ifc.busy) pl_idx = 0;
      ifc.pl_data = pl_mem[pl_idx];
    end
  end

  task automatic pwrup_init();
    int hi = 0;
    int t = 0;
    int bad = 0;
    int f0, b0, d0;
    f0 = frame_sizes.size();
    b0 = tx_q.size();
    d0 = dones;
    ifc.cmd = 8'h55;
    ifc.len = 6'd2;
    ifc.req = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk_10);
      if (csn) hi++;
      if (i == 10) ifc.req = 1'b0;
    end
    chk("pwrup_csn_high", hi, 21);
    @(negedge clk_10);
    chk("first_csn_low", csn, 1'b0);
    while (!ifc.ready && t < 400) begin
      @(negedge clk_10);
      t++;
    end
    chk("ready_rise", ifc.ready, 1'b1);
    chk("init_frames", frame_sizes.size() - f0, 5);
    for (int i = f0; i < frame_sizes.size(); i++)
      if (frame_sizes[i] != 2) bad++;
    chk("init_frame_size", bad, 0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("init_byte%0d", i), (b0 + i < tx_q.size()) ? tx_q[b0 + i] : 8'hxx, init_exp[i]);
    chk("init_no_done", dones - d0, 0);
    chk("init_busy", ifc.busy, 1'b0);
    chk("init_status", ifc.status, 8'h00);
  endtask

  task automatic txn(input logic [7:0] c, input logic [5:0] l, input int hold, input bit timing);
    int t = 0;
    @(negedge clk_10);
    ifc.cmd = c;
    ifc.len = l;
    ifc.req = 1'b1;
    @(negedge clk_10);
    if (hold == 0) ifc.req = 1'b0;
    if (timing) begin
      chk("acc_busy", ifc.busy, 1'b1);
      chk("acc_csn_high", csn, 1'b1);
    end
    @(negedge clk_10);
    if (timing) chk("sel_csn_low", csn, 1'b0);
    @(negedge clk_10);
    if (timing) begin
      chk("first_start", byte_start, 1'b1);
      chk("first_byte", byte_data, c);
    end
    while (!ifc.done && t < 2000) begin
      @(negedge clk_10);
      t++;
      if (t == hold) ifc.req = 1'b0;
    end
    ifc.req = 1'b0;
    chk("done_seen", ifc.done, 1'b1);
    chk("done_busy_clear", ifc.busy, 1'b0);
  endtask

  int f0, b0, r0, p0, d0, t;

  initial begin
    ifc.req = 1'b0;
    ifc.cmd = 8'h00;
    ifc.len = 6'd0;
    foreach (pl_mem[i]) pl_mem[i] = 8'h00;

    @(negedge clk_10);
    chk("rst_csn", csn, 1'b1);
    chk("rst_ready", ifc.ready, 1'b0);
    chk("rst_start", byte_start, 1'b0);
    repeat (2) @(posedge clk_10);
    #1 rst = 1'b0;
    pwrup_init();

    // cmd 0xA0, three payload bytes
    pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
    f0 = frame_sizes.size(); b0 = tx_q.size(); r0 = rd_q.size(); p0 = pl_acks; d0 = dones;
    txn(8'hA0, 6'd3, 0, 1'b1);
    chk("t1_frames", frame_sizes.size() - f0, 1);
    chk("t1_frame_len", frame_sizes[f0], 4);
    chk("t1_pl_acks", pl_acks - p0, 3);
    chk("t1_status", ifc.status, 8'hA0);
    chk("t1_rd_count", rd_q.size() - r0, 3);
    chk("t1_rd0", rd_q[r0], 8'hA1);
    chk("t1_rd1", rd_q[r0 + 1], 8'hA2);
    chk("t1_rd2", rd_q[r0 + 2], 8'hA3);
    chk("t1_tx1", tx_q[b0 + 1], 8'h11);
    chk("t1_tx2", tx_q[b0 + 2], 8'h22);
    chk("t1_tx3", tx_q[b0 + 3], 8'h33);
    chk("t1_dones", dones - d0, 1);
    chk("t1_done_lat", done_lat, GAPC + 1);

    // cmd 0xFF, no payload
    f0 = frame_sizes.size(); b0 = tx_q.size(); r0 = rd_q.size(); p0 = pl_acks;
    txn(8'hFF, 6'd0, 0, 1'b0);
    chk("t2_frame_len", frame_sizes[f0], 1);
    chk("t2_tx0", tx_q[b0], 8'hFF);
    chk("t2_pl_acks", pl_acks - p0, 0);
    chk("t2_rd_count", rd_q.size() - r0, 0);
    chk("t2_done_lat", done_lat, 5);

    // len 40 clamps to 32; req held for 50 cycles while busy
    for (int i = 0; i < 40; i++) pl_mem[i] = 8'(i + 1);
    f0 = frame_sizes.size(); b0 = tx_q.size(); r0 = rd_q.size(); p0 = pl_acks; d0 = dones;
    txn(8'hA5, 6'd40, 50, 1'b0);
    repeat (20) @(negedge clk_10);
    chk("t3_frames", frame_sizes.size() - f0, 1);
    chk("t3_frame_len", frame_sizes[f0], 33);
    chk("t3_pl_acks", pl_acks - p0, 32);
    chk("t3_rd_count", rd_q.size() - r0, 32);
    chk("t3_rd_last", rd_q[rd_q.size() - 1], 8'hC0);
    chk("t3_tx_first", tx_q[b0 + 1], 8'h01);
    chk("t3_tx_last", tx_q[tx_q.size() - 1], 8'h20);
    chk("t3_dones", dones - d0, 1);
    chk("t3_idle_busy", ifc.busy, 1'b0);

    // reset during the second payload byte
    r0 = rd_q.size();
    @(negedge clk_10);
    ifc.cmd = 8'h61;
    ifc.len = 6'd4;
    ifc.req = 1'b1;
    @(posedge clk_10);
    #1 ifc.req = 1'b0;
    t = 0;
    while (rd_q.size() == r0 && t < 200) begin
      @(negedge clk_10);
      t++;
    end
    chk("t4_first_rd", rd_q.size() - r0, 1);
    repeat (3) @(negedge clk_10);
    chk("t4_pre_csn", csn, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_csn", csn, 1'b1);
    chk("t4_rst_busy", ifc.busy, 1'b0);
    chk("t4_rst_ready", ifc.ready, 1'b0);
    chk("t4_rst_status", ifc.status, 8'h00);
    repeat (2) @(posedge clk_10);
    #1 rst = 1'b0;
    pwrup_init();

    chk("bad_starts", bad_starts, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
